// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pong_game_ctrl
//  Description : Pong game sequencer. Owns ball position/velocity, paddle and
//                wall collision resolution, scoring, serve/point timing and
//                the game state machine. All motion and delay counting is
//                paced by the single-cycle 'tick' strobe.
//                Optional macro PONG_SPEEDUP_EN: rally hit counter raises the
//                ball speed (1 + hits/4, capped at 3 px/tick).
//  Revision    : 1.0 - initial release
// ============================================================================
module pong_game_ctrl #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int PADDLE_SIZE   = 64,
    parameter int PADDLE_WIDTH  = 16,
    parameter int BALL_SIZE     = 8,
    parameter int WIN_SCORE     = 9,
    parameter int SERVE_DELAY   = 60,
    parameter int POINT_DELAY   = 30
) (
    input  logic       clk_25mhz,
    input  logic       locked,
    input  logic       tick,
    input  logic       start,
    input  logic [9:0] paddle1_y,
    input  logic [9:0] paddle2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       ball_visible,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [2:0] state,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_RALLY = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [9:0]         c_CX        = 10'(SCREEN_WIDTH / 2);
    localparam logic [9:0]         c_CY        = 10'(SCREEN_HEIGHT / 2);
    localparam logic signed [10:0] c_CXS       = 11'(SCREEN_WIDTH / 2);
    localparam logic signed [10:0] c_CYS       = 11'(SCREEN_HEIGHT / 2);
    localparam logic signed [10:0] c_BS        = 11'(BALL_SIZE);
    localparam logic signed [10:0] c_PW        = 11'(PADDLE_WIDTH);
    localparam logic signed [10:0] c_PS        = 11'(PADDLE_SIZE);
    localparam logic signed [10:0] c_SW        = 11'(SCREEN_WIDTH);
    localparam logic signed [10:0] c_SH        = 11'(SCREEN_HEIGHT);
    localparam logic signed [10:0] c_XMAX      = 11'(SCREEN_WIDTH - BALL_SIZE);
    localparam logic signed [10:0] c_YMAX      = 11'(SCREEN_HEIGHT - BALL_SIZE);
    localparam logic [3:0]         c_WIN       = 4'(WIN_SCORE);
    localparam logic [7:0]         c_SERVE_DLY = 8'(SERVE_DELAY);
    localparam logic [7:0]         c_POINT_DLY = 8'(POINT_DELAY);

    state_t             r_state, w_state;
    logic [9:0]         r_ball_x, w_ball_x;
    logic [9:0]         r_ball_y, w_ball_y;
    logic               r_visible, w_visible;
    logic [3:0]         r_score1, w_score1;
    logic [3:0]         r_score2, w_score2;
    logic [1:0]         r_winner, w_winner;
    logic signed [10:0] r_vx, w_vx;
    logic signed [10:0] r_vy, w_vy;
    logic               r_serve_dir, w_serve_dir;   // 1: next serve goes right
    logic               r_serve_up, w_serve_up;     // 1: next launch moves up
    logic [7:0]         r_cnt, w_cnt;
    logic               r_start_q;

    logic               w_start_edge;
    logic signed [10:0] w_bx, w_by, w_p1, w_p2;
    logic signed [10:0] w_speed;
    logic               w_left_zone, w_left_ovl;
    logic               w_right_zone, w_right_ovl;
    logic               w_top_hit, w_bot_hit;
    logic               w_scored;

`ifdef PONG_SPEEDUP_EN
    logic [3:0]         r_hits, w_hits;

    // Ball speed grows by one every four paddle hits, up to 3 px/tick
    always_comb begin
        case (r_hits[3:2])
            2'd0:    w_speed = 11'sd1;
            2'd1:    w_speed = 11'sd2;
            default: w_speed = 11'sd3;
        endcase
    end
`else
    assign w_speed = 11'sd1;
`endif

    function automatic logic signed [10:0] f_dir(input logic neg,
                                                 input logic signed [10:0] mag);
        return neg ? -mag : mag;
    endfunction

    function automatic logic signed [10:0] f_clamp(input logic signed [10:0] v,
                                                   input logic signed [10:0] hi);
        if (v < c_BS)
            return c_BS;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    assign w_start_edge = start & ~r_start_q;
    assign w_bx         = $signed({1'b0, r_ball_x});
    assign w_by         = $signed({1'b0, r_ball_y});
    assign w_p1         = $signed({1'b0, paddle1_y});
    assign w_p2         = $signed({1'b0, paddle2_y});

    assign w_left_zone  = (r_vx < 0) && (w_bx - c_BS <= c_PW);
    assign w_left_ovl   = (w_by + c_BS > w_p1) && (w_by - c_BS < w_p1 + c_PS);
    assign w_right_zone = (r_vx > 0) && (w_bx + c_BS >= c_SW - c_PW);
    assign w_right_ovl  = (w_by + c_BS > w_p2) && (w_by - c_BS < w_p2 + c_PS);
    assign w_top_hit    = (w_by == c_BS) && (r_vy < 0);
    assign w_bot_hit    = (w_by + c_BS == c_SH) && (r_vy > 0);

    // Next-state and datapath update for the game sequencer
    always_comb begin
        w_state     = r_state;
        w_ball_x    = r_ball_x;
        w_ball_y    = r_ball_y;
        w_visible   = r_visible;
        w_score1    = r_score1;
        w_score2    = r_score2;
        w_winner    = r_winner;
        w_vx        = r_vx;
        w_vy        = r_vy;
        w_serve_dir = r_serve_dir;
        w_serve_up  = r_serve_up;
        w_cnt       = r_cnt;
        w_scored    = 1'b0;
`ifdef PONG_SPEEDUP_EN
        w_hits      = r_hits;
`endif
        case (r_state)
            ST_IDLE, ST_OVER: begin
                w_visible = 1'b0;
                if (w_start_edge) begin
                    w_state     = ST_SERVE;
                    w_visible   = 1'b1;
                    w_ball_x    = c_CX;
                    w_ball_y    = c_CY;
                    w_score1    = 4'd0;
                    w_score2    = 4'd0;
                    w_winner    = 2'd0;
                    w_serve_dir = 1'b1;
                    w_cnt       = c_SERVE_DLY;
`ifdef PONG_SPEEDUP_EN
                    w_hits      = 4'd0;
`endif
                end
            end
            ST_SERVE: begin
                w_visible = 1'b1;
                if (tick) begin
                    if (r_cnt == 8'd0) begin
                        // Launch: the launch tick already moves the ball
                        w_state    = ST_RALLY;
                        w_vx       = f_dir(~r_serve_dir, w_speed);
                        w_vy       = f_dir(r_serve_up, w_speed);
                        w_serve_up = ~r_serve_up;
                        w_ball_x   = 10'(c_CXS + w_vx);
                        w_ball_y   = 10'(c_CYS + w_vy);
                    end else begin
                        w_cnt = r_cnt - 8'd1;
                    end
                end
            end
            ST_RALLY: begin
                w_visible = 1'b1;
                if (tick) begin
                    if (w_left_zone) begin
                        if (w_left_ovl) begin
                            w_vx = w_speed;
                            w_vy = f_dir(r_vy[10], w_speed);
`ifdef PONG_SPEEDUP_EN
                            w_hits = (r_hits == 4'hF) ? r_hits : r_hits + 4'd1;
`endif
                        end else if (w_bx == c_BS) begin
                            w_scored    = 1'b1;
                            w_score2    = (r_score2 == c_WIN) ? r_score2 : r_score2 + 4'd1;
                            w_serve_dir = 1'b0;
                        end
                    end
                    if (w_right_zone) begin
                        if (w_right_ovl) begin
                            w_vx = -w_speed;
                            w_vy = f_dir(r_vy[10], w_speed);
`ifdef PONG_SPEEDUP_EN
                            w_hits = (r_hits == 4'hF) ? r_hits : r_hits + 4'd1;
`endif
                        end else if (w_bx + c_BS == c_SW) begin
                            w_scored    = 1'b1;
                            w_score1    = (r_score1 == c_WIN) ? r_score1 : r_score1 + 4'd1;
                            w_serve_dir = 1'b1;
                        end
                    end
                    if (w_scored) begin
                        w_state   = ST_POINT;
                        w_visible = 1'b0;
                        w_ball_x  = c_CX;
                        w_ball_y  = c_CY;
                        w_cnt     = c_POINT_DLY;
                    end else begin
                        if (w_top_hit) begin
                            w_vy = w_speed;
                            w_vx = f_dir(w_vx[10], w_speed);
                        end else if (w_bot_hit) begin
                            w_vy = -w_speed;
                            w_vx = f_dir(w_vx[10], w_speed);
                        end
                        // Clamping lands the ball exactly on every edge
                        w_ball_x = 10'(f_clamp(w_bx + w_vx, c_XMAX));
                        w_ball_y = 10'(f_clamp(w_by + w_vy, c_YMAX));
                    end
                end
            end
            ST_POINT: begin
                w_visible = 1'b0;
                if (tick) begin
                    if (r_cnt == 8'd0) begin
                        if ((r_score1 == c_WIN) || (r_score2 == c_WIN)) begin
                            w_state  = ST_OVER;
                            w_winner = (r_score1 == c_WIN) ? 2'd1 : 2'd2;
                        end else begin
                            w_state   = ST_SERVE;
                            w_visible = 1'b1;
                            w_cnt     = c_SERVE_DLY;
`ifdef PONG_SPEEDUP_EN
                            w_hits    = 4'd0;
`endif
                        end
                    end else begin
                        w_cnt = r_cnt - 8'd1;
                    end
                end
            end
            default: begin
                w_state   = ST_IDLE;
                w_visible = 1'b0;
                w_ball_x  = c_CX;
                w_ball_y  = c_CY;
            end
        endcase
    end

    // State and datapath registers; PLL lock loss abandons the game at once
    always_ff @(posedge clk_25mhz or negedge locked) begin
        if (!locked) begin
            r_state     <= ST_IDLE;
            r_ball_x    <= c_CX;
            r_ball_y    <= c_CY;
            r_visible   <= 1'b0;
            r_score1    <= 4'd0;
            r_score2    <= 4'd0;
            r_winner    <= 2'd0;
            r_vx        <= 11'sd1;
            r_vy        <= -11'sd1;
            r_serve_dir <= 1'b1;
            r_serve_up  <= 1'b1;
            r_cnt       <= 8'd0;
            r_start_q   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_ball_x    <= w_ball_x;
            r_ball_y    <= w_ball_y;
            r_visible   <= w_visible;
            r_score1    <= w_score1;
            r_score2    <= w_score2;
            r_winner    <= w_winner;
            r_vx        <= w_vx;
            r_vy        <= w_vy;
            r_serve_dir <= w_serve_dir;
            r_serve_up  <= w_serve_up;
            r_cnt       <= w_cnt;
            r_start_q   <= start;
        end
    end

`ifdef PONG_SPEEDUP_EN
    // Rally hit counter, cleared whenever a serve begins
    always_ff @(posedge clk_25mhz or negedge locked) begin
        if (!locked)
            r_hits <= 4'd0;
        else
            r_hits <= w_hits;
    end
`endif

    assign ball_x       = r_ball_x;
    assign ball_y       = r_ball_y;
    assign ball_visible = r_visible;
    assign score1       = r_score1;
    assign score2       = r_score2;
    assign state        = r_state;
    assign winner       = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pong_game_ctrl
//  Description : Scoreboard bench for pong_game_ctrl. Stimulus pushes
//                hand-computed expectations tagged with the cycle they become
//                valid; a monitor pops and compares them on falling edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

    localparam int S_STATE = 0;
    localparam int S_BX    = 1;
    localparam int S_BY    = 2;
    localparam int S_VIS   = 3;
    localparam int S_SC1   = 4;
    localparam int S_SC2   = 5;
    localparam int S_WIN   = 6;

    logic       clk_25mhz = 1'b0;
    logic       locked;
    logic       tick;
    logic       start;
    logic [9:0] paddle1_y;
    logic [9:0] paddle2_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       ball_visible;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [2:0] state;
    logic [1:0] winner;

    typedef struct {
        int    due;
        int    sel;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   g_due    = 0;
    int   n_checks = 0;
    int   n_err    = 0;

    pong_game_ctrl dut (
        .clk_25mhz    (clk_25mhz),
        .locked       (locked),
        .tick         (tick),
        .start        (start),
        .paddle1_y    (paddle1_y),
        .paddle2_y    (paddle2_y),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .ball_visible (ball_visible),
        .score1       (score1),
        .score2       (score2),
        .state        (state),
        .winner       (winner)
    );

    always #5 clk_25mhz = ~clk_25mhz;

    // Cycle counter used to tag when an expectation becomes valid
    always @(posedge clk_25mhz) cyc <= cyc + 1;

    function automatic int act_of(input int sel);
        case (sel)
            S_STATE: return int'(state);
            S_BX:    return int'(ball_x);
            S_BY:    return int'(ball_y);
            S_VIS:   return int'(ball_visible);
            S_SC1:   return int'(score1);
            S_SC2:   return int'(score2);
            default: return int'(winner);
        endcase
    endfunction

    // Monitor: compare every expectation that has come due
    initial begin
        exp_t e;
        int   a;
        forever begin
            @(negedge clk_25mhz);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                a = act_of(e.sel);
                n_checks++;
                if (a != e.val) begin
                    n_err++;
                    $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, a, e.val, cyc);
                end
            end
        end
    end

    task automatic ex(input string nm, input int sel, input int val);
        exp_t e;
        e.due  = g_due;
        e.sel  = sel;
        e.val  = val;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic ex_ball(input string nm, input int x, input int y);
        ex({nm, ".x"}, S_BX, x);
        ex({nm, ".y"}, S_BY, y);
    endtask

    // One idle cycle, then tick/start high for exactly one cycle
    task automatic step(input logic t, input logic s);
        @(negedge clk_25mhz);
        tick  = 1'b0;
        start = 1'b0;
        @(negedge clk_25mhz);
        tick  = t;
        start = s;
        g_due = cyc + 1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        locked    = 1'b0;
        tick      = 1'b0;
        start     = 1'b0;
        paddle1_y = 10'd0;
        paddle2_y = 10'd0;
        repeat (3) @(negedge clk_25mhz);
        g_due = cyc;
        ex("rst.state", S_STATE, 0);
        ex_ball("rst.ball", 320, 240);
        ex("rst.vis", S_VIS, 0);
        ex("rst.s1", S_SC1, 0);
        ex("rst.s2", S_SC2, 0);
        ex("rst.win", S_WIN, 0);
        @(negedge clk_25mhz);
        locked = 1'b1;

        // Game 1: serve right, top bounce, right miss
        step(1'b0, 1'b1);
        ex("g1.start.state", S_STATE, 1);
        ex("g1.start.vis", S_VIS, 1);
        ex_ball("g1.start.ball", 320, 240);
        ticks(60);
        ex("g1.serve_hold", S_STATE, 1);
        step(1'b1, 1'b0);
        ex("g1.launch.state", S_STATE, 2);
        ex_ball("g1.launch", 321, 239);
        ticks(231);
        ex_ball("g1.at_top", 552, 8);
        step(1'b0, 1'b1);
        ex("g1.start_ignored", S_STATE, 2);
        ex_ball("g1.start_ignored", 552, 8);
        step(1'b1, 1'b0);
        ex_ball("g1.top_bounce", 553, 9);
        ex("g1.top.s1", S_SC1, 0);
        ex("g1.top.s2", S_SC2, 0);
        ticks(79);
        ex_ball("g1.right_edge", 632, 88);
        ex("g1.right_edge.state", S_STATE, 2);
        step(1'b1, 1'b0);
        ex("g1.miss.s1", S_SC1, 1);
        ex("g1.miss.s2", S_SC2, 0);
        ex("g1.miss.state", S_STATE, 3);
        ex("g1.miss.vis", S_VIS, 0);
        ex_ball("g1.miss.ball", 320, 240);
        paddle2_y = 10'd380;
        ticks(30);
        ex("g1.point_hold", S_STATE, 3);
        step(1'b1, 1'b0);
        ex("g1.reserve.state", S_STATE, 1);
        ex("g1.reserve.vis", S_VIS, 1);
        ticks(60);
        step(1'b1, 1'b0);
        ex("g1.launch2.state", S_STATE, 2);
        ex_ball("g1.launch2", 321, 241);
        ticks(231);
        ex_ball("g1.at_bottom", 552, 472);
        step(1'b1, 1'b0);
        ex_ball("g1.bottom_bounce", 553, 471);
        ticks(63);
        ex_ball("g1.at_rpaddle", 616, 408);
        step(1'b1, 1'b0);
        ex_ball("g1.rpaddle_bounce", 615, 407);
        paddle1_y = 10'd200;
        ticks(399);
        ex_ball("g1.at_top2", 216, 8);
        step(1'b1, 1'b0);
        ex_ball("g1.top2_bounce", 215, 9);
        ticks(191);
        ex_ball("g1.at_lpaddle", 24, 200);
        step(1'b1, 1'b0);
        ex_ball("g1.lpaddle_bounce", 25, 201);
        ticks(5);

        // Lock loss mid-rally
        @(posedge clk_25mhz);
        #2;
        locked = 1'b0;
        g_due  = cyc;
        ex("lock.state", S_STATE, 0);
        ex("lock.s1", S_SC1, 0);
        ex("lock.vis", S_VIS, 0);
        ex_ball("lock.ball", 320, 240);
        @(negedge clk_25mhz);
        tick = 1'b0;
        repeat (2) @(negedge clk_25mhz);
        locked = 1'b1;

        // Game 2: start with tick, right paddle return, left misses to game over
        paddle1_y = 10'd900;
        paddle2_y = 10'd40;
        step(1'b1, 1'b1);
        ex("g2.start.state", S_STATE, 1);
        ex("g2.start.vis", S_VIS, 1);
        ticks(60);
        ex("g2.serve_hold", S_STATE, 1);
        step(1'b1, 1'b0);
        ex("g2.launch.state", S_STATE, 2);
        ex_ball("g2.launch", 321, 239);
        ticks(231);
        ex_ball("g2.at_top", 552, 8);
        step(1'b1, 1'b0);
        ticks(63);
        ex_ball("g2.at_rpaddle", 616, 72);
        step(1'b1, 1'b0);
        ex_ball("g2.rpaddle_bounce", 615, 73);
        ticks(399);
        ex_ball("g2.at_bottom", 216, 472);
        step(1'b1, 1'b0);
        ex_ball("g2.bottom_bounce", 215, 471);
        ticks(207);
        ex_ball("g2.left_edge", 8, 264);
        step(1'b1, 1'b0);
        ex("g2.miss1.s2", S_SC2, 1);
        ex("g2.miss1.s1", S_SC1, 0);
        ex("g2.miss1.state", S_STATE, 3);
        for (int p = 2; p <= 9; p++) begin
            ticks(31);
            ex("g2.loop.serve", S_STATE, 1);
            ticks(61);
            ex("g2.loop.launch", S_STATE, 2);
            ex_ball("g2.loop.launch", 319, (p % 2 == 0) ? 241 : 239);
            ticks(311);
            ex("g2.loop.left_edge.x", S_BX, 8);
            step(1'b1, 1'b0);
            ex("g2.loop.miss.s2", S_SC2, p);
            ex("g2.loop.miss.state", S_STATE, 3);
        end
        ticks(30);
        ex("g2.final_point_hold", S_STATE, 3);
        ex("g2.final_point_win", S_WIN, 0);
        step(1'b1, 1'b0);
        ex("g2.over.state", S_STATE, 4);
        ex("g2.over.win", S_WIN, 2);
        ex("g2.over.vis", S_VIS, 0);
        ex("g2.over.s2", S_SC2, 9);
        ex("g2.over.s1", S_SC1, 0);
        step(1'b0, 1'b1);
        ex("g2.restart.state", S_STATE, 1);
        ex("g2.restart.s2", S_SC2, 0);
        ex("g2.restart.win", S_WIN, 0);
        ex("g2.restart.vis", S_VIS, 1);
        step(1'b0, 1'b0);
        repeat (3) @(negedge clk_25mhz);

        n_checks++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game sequencer for the HDMI pong display.
- Owns ball position and velocity, collision resolution, scoring, serve timing and the game state machine.
- Paces all motion from a frame/move tick strobe.
- Feeds ball_x, ball_y, score1, score2 and ball_visible to the pixel colour logic; paddle positions come in from the button/GPIO paddle logic.

Parameters:
- SCREEN_WIDTH, 640, visible width in pixels
- SCREEN_HEIGHT, 480, visible height in pixels
- PADDLE_SIZE, 64, paddle height
- PADDLE_WIDTH, 16, paddle thickness (paddles at x 0 and SCREEN_WIDTH-PADDLE_WIDTH)
- BALL_SIZE, 8, ball half-extent
- WIN_SCORE, 9, points to win (must be 1..15)
- SERVE_DELAY, 60, ticks the ball is held at centre before launch
- POINT_DELAY, 30, ticks the ball is hidden after a point

Ports:
- clk_25mhz  in  1  pixel clock; sole clock
- locked  in  1  asynchronous active-low reset (PLL lock); low = reset
- tick  in  1  single-cycle move strobe; all motion and delay counting happen only on tick cycles
- start  in  1  start/restart request level; rising edge detected internally on clk_25mhz
- paddle1_y  in  10  left paddle top row
- paddle2_y  in  10  right paddle top row
- ball_x  out  10  ball centre x
- ball_y  out  10  ball centre y
- ball_visible  out  1  high when ball is drawn
- score1  out  4  left player score
- score2  out  4  right player score
- state  out  3  IDLE=0, SERVE=1, RALLY=2, POINT=3, OVER=4
- winner  out  2  0 none, 1 left, 2 right

Behaviour:
- Reset (locked low, async): state IDLE, ball_x=SCREEN_WIDTH/2, ball_y=SCREEN_HEIGHT/2, ball_visible=0, scores 0, winner 0, vx=+1, vy=-1, serve_dir=+1, delay counter 0, start edge register cleared. Reset mid-game abandons all state immediately.
- Start edge: start high this cycle and low the previous cycle. Acted on in IDLE and OVER only; ignored in other states.
- IDLE: ball centred, hidden. On start edge: scores 0, winner 0, serve_dir=+1, counter=SERVE_DELAY, go SERVE. A start edge takes priority over a tick in the same cycle; that tick is not counted.
- SERVE:
  - Ball centred, visible.
  - Each tick: if counter==0, go RALLY with vx=serve_dir and vy=serve_vy, then toggle serve_vy; otherwise decrement counter.
  - Launch happens on tick SERVE_DELAY+1 after entry.
- RALLY: each tick, in this order, on the current position:
  - Left zone: vx<0 and ball_x-BALL_SIZE <= PADDLE_WIDTH.
    - Overlap is ball_y+BALL_SIZE > paddle1_y and ball_y-BALL_SIZE < paddle1_y+PADDLE_SIZE. Overlap -> vx=+speed.
    - No overlap and ball_x-BALL_SIZE==0 -> score2+1, serve_dir=-1, go POINT.
  - Right zone mirrors this with paddle2_y and ball_x+BALL_SIZE==SCREEN_WIDTH; a miss gives score1+1, serve_dir=+1.
  - Top wall: ball_y-BALL_SIZE==0 with vy<0 -> vy=+speed. Bottom wall: ball_y+BALL_SIZE==SCREEN_HEIGHT with vy>0 -> vy=-speed. A wall bounce and a paddle bounce in the same tick both apply.
  - Unless a point is scored, position becomes pos+updated velocity, clamped to [BALL_SIZE, SCREEN-BALL_SIZE] per axis, so edges are always hit exactly.
  - Arithmetic is 11-bit signed internally; outputs are 10-bit.
- POINT:
  - On entry: ball hidden, centred, counter=POINT_DELAY.
  - Each tick decrements the counter. At counter==0 on a tick:
    - Either score==WIN_SCORE -> OVER; winner=1 if score1==WIN_SCORE, else 2.
    - Otherwise -> SERVE with counter=SERVE_DELAY.
- OVER: ball hidden, scores and winner held. On start edge, behave exactly as IDLE start.
- Scores saturate at WIN_SCORE and never wrap.
- Outputs are registered; any change is visible the cycle after the tick.

Optional Feature:
- Macro: PONG_SPEEDUP_EN.
- Defined:
  - A rally hit counter counts paddle bounces and clears on each serve.
  - speed = 1 + hits/4, capped at 3 px/tick. It applies to both axes on every bounce and at launch.
  - Clamping guarantees exact edge detection.
- Undefined: speed is fixed at 1; no hit counter logic is synthesised.

Test Plan:
- Reset then locked=1, start pulse, 61 ticks -> state=RALLY, ball at (321,239) after the launch tick, vx=+1, vy=-1.
- Force a rally with paddle2_y=0 while the ball descends near the right edge -> score1 increments to 1, state=POINT, ball_visible=0; 31 ticks later state=SERVE and launch is toward the right.
- Ball reaches top wall (ball_y=8) with vy=-1 and ball_x=320 -> next tick ball_y=9; no score change.
- Left paddle at paddle1_y=200, ball arrives at ball_x=24, ball_y=230, vx=-1 -> vx becomes +1, ball_x=25.
- Preload score2=8 by play, then a left miss -> score2=9, after POINT_DELAY state=OVER, winner=2; a further start edge -> scores 0, state=SERVE.
- Assert locked low mid-RALLY -> same cycle state=IDLE, scores 0, ball centred, hidden; start coincident with tick in IDLE -> SERVE counter=60, not 59.
